// File: rtl/constants_pkg.sv
// Shared widths and types for the instruction-fetch memory path.
package constants_pkg;
  localparam int XLEN          = 32;
  localparam int ILEN          = 32;
  localparam int ICLLEN        = 128;
  localparam int ICLWORDS      = ICLLEN / ILEN;
  localparam int LINE_OFF_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } icrsp_state_t;
endpackage

// File: rtl/imem_array.sv
// Instruction backing store: one word write port, one line-wide asynchronous read port.
// Contents are never reset.
module imem_array
  import constants_pkg::*;
#(
  parameter  int MEM_WORDS = 4096,
  localparam int AW        = $clog2(MEM_WORDS),
  localparam int LW        = AW - 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [ILEN-1:0]   wdata_i,
  input  logic [LW-1:0]     raddr_i,
  output logic [ICLLEN-1:0] rdata_o
);

  logic [ILEN-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  for (genvar w = 0; w < ICLWORDS; w++) begin : g_rd
    assign rdata_o[w*ILEN +: ILEN] = mem[{raddr_i, 2'(w)}];
  end

endmodule

// File: rtl/icache_mem_responder.sv
// Fixed-latency line-fill responder for the instruction cache, with a program-load port.
// Define ICACHE_RSP_ERR_EN to flag out-of-range lines instead of wrapping them.
module icache_mem_responder
  import constants_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [XLEN-1:0]   req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [ICLLEN-1:0] rsp_data_o,
  output logic              rsp_err_o,
  input  logic              ld_we_i,
  input  logic [XLEN-1:0]   ld_addr_i,
  input  logic [ILEN-1:0]   ld_data_i
);

  localparam int AW     = $clog2(MEM_WORDS);
  localparam int LW     = AW - 2;
  localparam int LINE_W = XLEN - LINE_OFF_BITS;

  icrsp_state_t      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ICLLEN-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [ICLLEN-1:0] rd_line;
  logic              line_oob;
  logic              ld_en;
  logic              unused_bits;

  assign ld_en = ld_we_i && (ld_addr_i < XLEN'(MEM_WORDS * 4));

  imem_array #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk     (clk),
    .we_i    (ld_en),
    .waddr_i (ld_addr_i[AW+1:2]),
    .wdata_i (ld_data_i),
    .raddr_i (line_q[LW-1:0]),
    .rdata_o (rd_line)
  );

`ifdef ICACHE_RSP_ERR_EN
  assign line_oob    = (line_q >= LINE_W'(MEM_WORDS / 4));
  assign unused_bits = ^{req_addr_i[LINE_OFF_BITS-1:0], ld_addr_i[1:0], ld_addr_i[XLEN-1:AW+2]};
`else
  // Upper line bits drop out: the index wraps onto the array.
  assign line_oob    = 1'b0;
  assign unused_bits = ^{req_addr_i[LINE_OFF_BITS-1:0], ld_addr_i[1:0], ld_addr_i[XLEN-1:AW+2],
                         line_q[LINE_W-1:LW]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = WAIT;
          line_d  = req_addr_i[XLEN-1:LINE_OFF_BITS];
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          // Array read sees pre-edge contents, so a same-edge load write is excluded.
          state_d = RESP;
          data_d  = line_oob ? '0 : rd_line;
          err_d   = line_oob;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Randomized bench for icache_mem_responder against a transaction-level memory model.
module tb_icache_mem_responder;
  localparam int LAT = 4;
  localparam int MW  = 4096;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [31:0]  req_addr_i = '0;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b1;
  logic [127:0] rsp_data_o;
  logic         rsp_err_o;
  logic         ld_we_i = 1'b0;
  logic [31:0]  ld_addr_i = '0;
  logic [31:0]  ld_data_i = '0;

  always #5 clk = ~clk;

  icache_mem_responder #(.LATENCY(LAT), .MEM_WORDS(MW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .ld_we_i     (ld_we_i),
    .ld_addr_i   (ld_addr_i),
    .ld_data_i   (ld_data_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: memory image plus one outstanding transaction tracked by edges since accept.
  logic [31:0]  tb_mem [MW];
  bit           in_flight = 0;
  int           e = 0;
  logic [27:0]  cur_line = '0;
  logic [127:0] exp_data = '0;
  logic         exp_err = 1'b0;

  localparam logic [127:0] L1000 = 128'h00000044_00000033_00000022_00000011;

  task automatic chk(string tag, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] line_of(logic [27:0] ln);
    logic [127:0] r;
    int base;
    base = int'(ln % 28'(MW / 4)) * 4;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = tb_mem[base + w];
    return r;
  endfunction

  task automatic tick();
    bit acc, hs;
    acc = req_valid_i && !in_flight;
    hs  = in_flight && (e >= LAT) && rsp_ready_i;
    if (in_flight && e == LAT - 1) begin
`ifdef ICACHE_RSP_ERR_EN
      exp_err  = (cur_line >= 28'(MW / 4));
      exp_data = exp_err ? '0 : line_of(cur_line);
`else
      exp_err  = 1'b0;
      exp_data = line_of(cur_line);
`endif
    end
    if (acc) cur_line = req_addr_i[31:4];
    if (ld_we_i && ld_addr_i < 32'(MW * 4)) tb_mem[int'(ld_addr_i >> 2)] = ld_data_i;
    @(posedge clk);
    #1;
    if (acc) begin
      in_flight = 1;
      e = 0;
    end else if (in_flight) begin
      e++;
    end
    if (hs) in_flight = 0;
    chk("req_ready", 128'(req_ready_o), 128'(!in_flight));
    chk("rsp_valid", 128'(rsp_valid_o), 128'(in_flight && e >= LAT));
    if (in_flight && e >= LAT) begin
      chk("rsp_data", rsp_data_o, exp_data);
      chk("rsp_err", 128'(rsp_err_o), 128'(exp_err));
    end
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (in_flight && n < budget) begin
      tick();
      n++;
    end
    if (in_flight) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout act=busy exp=idle t=%0t", $time);
      in_flight = 0;
    end
  endtask

  task automatic send(logic [31:0] addr);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic ld(logic [31:0] addr, logic [31:0] data);
    ld_we_i   = 1'b1;
    ld_addr_i = addr;
    ld_data_i = data;
    tick();
    ld_we_i   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_ready", 128'(req_ready_o), 128'(1));
    chk("rst_valid", 128'(rsp_valid_o), 128'(0));
    chk("rst_data", rsp_data_o, 128'(0));
    chk("rst_err", 128'(rsp_err_o), 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < MW; i++) ld(32'(i * 4), $urandom);

    // Basic fill with fixed latency
    ld(32'h1000, 32'h11); ld(32'h1004, 32'h22); ld(32'h1008, 32'h33); ld(32'h100C, 32'h44);
    send(32'h1008);
    repeat (LAT - 1) tick();
    chk("t33_early", 128'(rsp_valid_o), 128'(0));
    tick();
    chk("t33_valid", 128'(rsp_valid_o), 128'(1));
    chk("t33_data", rsp_data_o, L1000);
    chk("t33_err", 128'(rsp_err_o), 128'(0));
    wait_idle(20);

    // Backpressure hold
    rsp_ready_i = 1'b0;
    send(32'h1008);
    repeat (LAT + 10) tick();
    chk("t34_valid", 128'(rsp_valid_o), 128'(1));
    chk("t34_data", rsp_data_o, L1000);
    chk("t34_ready", 128'(req_ready_o), 128'(0));
    rsp_ready_i = 1'b1;
    tick();
    chk("t34_ready_after", 128'(req_ready_o), 128'(1));

    // Back-to-back requests with held valid
    req_valid_i = 1'b1;
    req_addr_i  = 32'h1000;
    tick();
    req_addr_i  = 32'h2000;
    for (int k = 0; k < 3 * LAT + 10; k++) tick();
    req_valid_i = 1'b0;
    wait_idle(40);

    // Load write during WAIT visible, on RESP-entry edge not
    send(32'h1000);
    ld(32'h1000, 32'hDEADBEEF);
    while (in_flight && e < LAT - 1) tick();
    ld(32'h1000, 32'h12345678);
    chk("t36_w0", 128'(rsp_data_o[31:0]), 128'(32'hDEADBEEF));
    wait_idle(20);
    send(32'h1000);
    repeat (LAT) tick();
    chk("t36_w0b", 128'(rsp_data_o[31:0]), 128'(32'h12345678));
    wait_idle(20);

    // Out-of-range line
    send(32'h0001_0000);
    repeat (LAT) tick();
`ifdef ICACHE_RSP_ERR_EN
    chk("t37_err", 128'(rsp_err_o), 128'(1));
    chk("t37_data", rsp_data_o, 128'(0));
`else
    chk("t37_err", 128'(rsp_err_o), 128'(0));
    chk("t37_data", rsp_data_o, line_of(28'd0));
`endif
    wait_idle(20);

    // Reset mid-WAIT abandons the transaction
    send(32'h1000);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t38_valid", 128'(rsp_valid_o), 128'(0));
    chk("t38_ready", 128'(req_ready_o), 128'(1));
    in_flight = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 6) tick();

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      req_valid_i = ($urandom_range(0, 1) == 1);
      req_addr_i  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MW * 4 - 1));
      rsp_ready_i = ($urandom_range(0, 9) < 6);
      ld_we_i     = ($urandom_range(0, 4) == 0);
      ld_addr_i   = 32'($urandom_range(0, MW * 4 + 1023));
      ld_data_i   = $urandom;
      tick();
    end
    req_valid_i = 1'b0;
    ld_we_i     = 1'b0;
    rsp_ready_i = 1'b1;
    wait_idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
